aes_inv_mixcolumns: RTL and testbench

- Byte-serial AES InvMixColumns, used in the decryption datapath; the functional inverse of the team's forward MixColumns block.
- Takes a 128-bit state as four 32-bit columns and multiplies each column by the inverse matrix over GF(2^8).
- Inverse matrix rows: [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
- One multiply-accumulate per cycle: 64 compute cycles per state.

---
 rtl/aes_inv_mixcolumns.sv | 210 +++++++++++++++++++++
 tb/tb_aes_inv_mixcolumns.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_mixcolumns.sv
// ---------------------------------------------------------------------------
// aes_inv_mixcolumns
//
// Byte-serial AES InvMixColumns for the decryption datapath. A 128-bit state
// (four 32-bit columns) is multiplied column by column by the inverse
// MixColumns matrix over GF(2^8). One multiply-accumulate is performed per
// clock, so a full state takes 64 compute cycles after the accepted start.
//
// Optional build macro: AES_INV_MIXCOLUMNS_FWD_EN
//   When defined, adds a 'mode' input sampled with the start
//   (1 = inverse matrix, 0 = forward MixColumns matrix). Timing is identical.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   start_in            start request (level allowed; only 0->1 is used)
//   mode                (macro only) 1 = inverse, 0 = forward
//   state0..state3      input columns; byte r of column c = stateC[8r+7:8r]
//   state_out0..3       result columns, same packing, held until next result
//   busy                high while computing
//   done                result valid, held until next accepted start/reset
// ---------------------------------------------------------------------------
module aes_inv_mixcolumns (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
  input  logic        mode,
`endif
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        busy,
  output logic        done
);

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the matrix constants using the x2/x4/x8 chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (coef)
      8'h01:   gmul = a;
      8'h02:   gmul = x2;
      8'h03:   gmul = x2 ^ a;
      8'h09:   gmul = x8 ^ a;
      8'h0b:   gmul = x8 ^ x2 ^ a;
      8'h0d:   gmul = x8 ^ x4 ^ a;
      8'h0e:   gmul = x8 ^ x4 ^ x2;
      default: gmul = 8'h00;
    endcase
  endfunction

  // Matrix element M[row][term]: each row is the first row rotated right by
  // 'row', so the element depends only on (term - row) mod 4.
  function automatic logic [7:0] coef_sel(input logic [1:0] row, input logic [1:0] term,
                                          input logic inv);
    logic [1:0] idx;
    idx = term - row;
    if (inv) begin
      case (idx)
        2'd0:    coef_sel = 8'h0e;
        2'd1:    coef_sel = 8'h0b;
        2'd2:    coef_sel = 8'h0d;
        2'd3:    coef_sel = 8'h09;
        default: coef_sel = 8'h00;
      endcase
    end else begin
      case (idx)
        2'd0:    coef_sel = 8'h02;
        2'd1:    coef_sel = 8'h03;
        2'd2:    coef_sel = 8'h01;
        2'd3:    coef_sel = 8'h01;
        default: coef_sel = 8'h00;
      endcase
    end
  endfunction

  logic         start_prev_q, start_prev_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [5:0]   k_q, k_d;
  logic [7:0]   acc_q, acc_d;
  logic [127:0] in_q, in_d;
  logic [127:0] res_q, res_d;
  logic [127:0] out_q, out_d;

  logic         accept_s;
  logic         inv_sel_s;
  logic [1:0]   col_s, row_s, term_s;
  logic [7:0]   in_byte_s;
  logic [7:0]   prod_s;
  logic [7:0]   acc_sum_s;
  logic [127:0] res_upd_s;

`ifdef AES_INV_MIXCOLUMNS_FWD_EN
  logic mode_q, mode_d;
  assign inv_sel_s = mode_q;
`else
  assign inv_sel_s = 1'b1;
`endif

  // A rising start is accepted only when idle; edges while busy are dropped.
  assign accept_s = start_in & ~start_prev_q & ~busy_q;

  // Datapath for the current term: select operand, multiply, accumulate.
  always_comb begin
    col_s     = k_q[5:4];
    row_s     = k_q[3:2];
    term_s    = k_q[1:0];
    in_byte_s = in_q[{col_s, term_s, 3'b000} +: 8];
    prod_s    = gmul(in_byte_s, coef_sel(row_s, term_s, inv_sel_s));
    acc_sum_s = ((term_s == 2'd0) ? 8'h00 : acc_q) ^ prod_s;
    res_upd_s = res_q;
    if (term_s == 2'd3) begin
      res_upd_s[{col_s, row_s, 3'b000} +: 8] = acc_sum_s;
    end else begin
      res_upd_s = res_q;
    end
  end

  // Next-state logic for control, counters and buffers.
  always_comb begin
    start_prev_d = start_in;
    busy_d       = busy_q;
    done_d       = done_q;
    k_d          = k_q;
    acc_d        = acc_q;
    in_d         = in_q;
    res_d        = res_q;
    out_d        = out_q;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
    mode_d       = mode_q;
`endif
    if (accept_s) begin
      in_d   = {state3, state2, state1, state0};
      busy_d = 1'b1;
      done_d = 1'b0;
      k_d    = 6'd0;
      acc_d  = 8'h00;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
      mode_d = mode;
`endif
    end else if (busy_q) begin
      acc_d = acc_sum_s;
      res_d = res_upd_s;
      if (k_q == 6'd63) begin
        // Final byte lands in the buffer and the whole buffer goes out together.
        out_d  = res_upd_s;
        busy_d = 1'b0;
        done_d = 1'b1;
        k_d    = 6'd0;
      end else begin
        k_d = k_q + 6'd1;
      end
    end else begin
      k_d = k_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      k_q          <= 6'd0;
      acc_q        <= 8'h00;
      in_q         <= 128'd0;
      res_q        <= 128'd0;
      out_q        <= 128'd0;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      start_prev_q <= start_prev_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      in_q         <= in_d;
      res_q        <= res_d;
      out_q        <= out_d;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
      mode_q       <= mode_d;
`endif
    end
  end

  assign state_out0 = out_q[31:0];
  assign state_out1 = out_q[63:32];
  assign state_out2 = out_q[95:64];
  assign state_out3 = out_q[127:96];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_inv_mixcolumns.sv
module tb_aes_inv_mixcolumns;

  logic        clk;
  logic        reset;
  logic        start_in;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
  logic        mode;
`endif
  logic [31:0] state0, state1, state2, state3;
  logic [31:0] state_out0, state_out1, state_out2, state_out3;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cycles;
  int rises;
  logic done_prev;

  aes_inv_mixcolumns dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
    .mode       (mode),
`endif
    .state0     (state0),
    .state1     (state1),
    .state2     (state2),
    .state3     (state3),
    .state_out0 (state_out0),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedges after the start edge until done, bounded at 200.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    reset    = 1'b0;
    start_in = 1'b0;
`ifdef AES_INV_MIXCOLUMNS_FWD_EN
    mode     = 1'b1;
`endif
    state0 = 32'h0; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_out0", state_out0, 32'h0);
    check("rst_out3", state_out3, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Known inverse vector
    reset  = 1'b1;
    state0 = 32'hbca14d8e; state1 = 32'h9d58dc9f;
    state2 = 32'h01010101; state3 = 32'hc6c6c6c6;
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("t1_busy_e0", {31'd0, busy}, 32'd1);
    check("t1_done_e0", {31'd0, done}, 32'd0);
    wait_done(cycles);
    check("t1_latency", cycles, 32'd64);
    check("t1_out0", state_out0, 32'h455313db);
    check("t1_out1", state_out1, 32'h5c220af2);
    check("t1_out2", state_out2, 32'h01010101);
    check("t1_out3", state_out3, 32'hc6c6c6c6);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Held start: exactly one operation
    state0 = 32'hd6d7d5d5; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;
    @(negedge clk);
    start_in  = 1'b1;
    done_prev = done;
    rises     = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done && !done_prev) rises++;
      done_prev = done;
    end
    start_in = 1'b0;
    check("t2_rises", rises, 32'd1);
    check("t2_out0", state_out0, 32'hd5d4d4d4);
    check("t2_out1", state_out1, 32'h0);
    check("t2_out2", state_out2, 32'h0);
    check("t2_out3", state_out3, 32'h0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_done", {31'd0, done}, 32'd1);

    // Start while busy and input change after E0
    state0 = 32'hbca14d8e; state1 = 32'h9d58dc9f;
    state2 = 32'h01010101; state3 = 32'hc6c6c6c6;
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    state0   = 32'hffffffff;
    cycles   = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 30) start_in = 1'b1;
      if (cycles == 32) start_in = 1'b0;
    end
    check("t3_latency", cycles, 32'd64);
    check("t3_out0", state_out0, 32'h455313db);
    check("t3_out1", state_out1, 32'h5c220af2);
    @(negedge clk);
    check("t3_no_queue", {31'd0, busy}, 32'd0);

    // Reset mid-operation
    state0 = 32'hd6d7d5d5;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t4_out0", state_out0, 32'h0);
    check("t4_out1", state_out1, 32'h0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_done", {31'd0, done}, 32'd0);
    state0 = 32'h0; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_done(cycles);
    check("t4_latency", cycles, 32'd64);
    check("t4_zero_out0", state_out0, 32'h0);
    check("t4_zero_out2", state_out2, 32'h0);

    // Back-to-back operations, plus a start rising on the completion edge
    state0 = 32'hbca14d8e; state1 = 32'h9d58dc9f;
    state2 = 32'h01010101; state3 = 32'hc6c6c6c6;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    wait_done(cycles);
    check("t5_op1_latency", cycles, 32'd64);
    state0 = 32'hd6d7d5d5; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    check("t5_done_drop", {31'd0, done}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd1);
    check("t5_hold_e0", state_out0, 32'h455313db);
    cycles = 0;
    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (cycles == 63) begin
        check("t5_hold_e63", state_out0, 32'h455313db);
        start_in = 1'b1;
      end
    end
    check("t5_op2_latency", cycles, 32'd64);
    check("t5_out0", state_out0, 32'hd5d4d4d4);
    check("t5_out1", state_out1, 32'h0);
    check("t5_ign_cmpl", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start_in = 1'b0;
    check("t5_still_idle", {31'd0, busy}, 32'd0);

`ifdef AES_INV_MIXCOLUMNS_FWD_EN
    // Forward mode
    mode   = 1'b0;
    state0 = 32'h455313db; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    mode     = 1'b1;
    wait_done(cycles);
    check("fwd_latency", cycles, 32'd64);
    check("fwd_out0", state_out0, 32'hbca14d8e);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
